// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and parity-mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: enqueue handshake plus FIFO status flags.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
) ();

    logic              wr_en;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output wr_en,
        output tx_data,
        input  full,
        input  empty,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  tx_data,
        output full,
        output empty,
        output overflow
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a write into a full FIFO is taken only when a pop frees a slot.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q;
    logic [AW:0]       rptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_wr;
    logic              do_rd;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame settings are latched per word so config changes only affect later frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave wr_bus,
    input  logic [15:0]   baud_div,
    input  logic [1:0]    parity_mode,
    input  logic          two_stop,
    output logic          TX,
    output logic          tx_busy,
    output logic          tx_done
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_fifo: DATA_W must lie in 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    uart_state_e       state_q;
    logic [15:0]       baud_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [15:0]       div_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    logic              par_en_q;
    logic              two_stop_q;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_end;
    logic              stop_last;
    logic              pop;

    uart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_bus.wr_en),
        .rd_en (pop),
        .din   (wr_bus.tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bit_end   = (baud_cnt_q == div_q);
        stop_last = (bit_cnt_q == {3'b000, two_stop_q});
        pop       = !fifo_empty &&
                    ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end && stop_last));
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shreg_q    <= fifo_dout;
            div_q      <= baud_div;
            par_en_q   <= parity_on(parity_mode);
            par_q      <= parity_bit(9'(fifo_dout), parity_mode);
            two_stop_q <= two_stop;
        end else if (state_q == ST_DATA && bit_end) begin
            shreg_q <= shreg_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= wr_bus.wr_en && fifo_full && !pop;
            // TX trails the state by one cycle, giving the two-edge write-to-start-bit latency.
            case (state_q)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shreg_q[0];
                ST_PARITY: tx_q <= par_q;
                default:   tx_q <= 1'b1;
            endcase
            if (state_q == ST_IDLE || bit_end) baud_cnt_q <= '0;
            else                               baud_cnt_q <= baud_cnt_q + 16'd1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (stop_last) begin
                            done_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= pop ? ST_START : ST_IDLE;
                            busy_q    <= pop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX              = tx_q;
    assign tx_busy         = busy_q;
    assign tx_done         = done_q;
    assign wr_bus.full     = fifo_full;
    assign wr_bus.empty    = fifo_empty;
    assign wr_bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame tables, a per-cycle waveform model and multi-cycle corner sequences.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(8)) bus8 ();
    uart_tx_fifo_if #(.DATA_W(5)) bus5 ();

    logic [15:0] div8, div5;
    logic [1:0]  pm8, pm5;
    logic        ts8, ts5;
    logic        tx8, tx5, busy8, busy5, done8, done5;

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .wr_bus(bus8.slave), .baud_div(div8), .parity_mode(pm8),
        .two_stop(ts8), .TX(tx8), .tx_busy(busy8), .tx_done(done8)
    );

    uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(8)) dut5 (
        .clk(clk), .rst(rst), .wr_bus(bus5.slave), .baud_div(div5), .parity_mode(pm5),
        .two_stop(ts5), .TX(tx5), .tx_busy(busy5), .tx_done(done5)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;
    int done_cnt5 = 0;

    always @(posedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done5 === 1'b1) done_cnt5++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8:0]  data;
        int          div;
        logic [1:0]  mode;
        logic        two;
        logic [15:0] exp_bits;   // bit i = TX value of the i-th bit period
        int          exp_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx5 : tx8;
    endfunction

    function automatic logic dones(input bit sel);
        return sel ? done5 : done8;
    endfunction

    function automatic logic busys(input bit sel);
        return sel ? busy5 : busy8;
    endfunction

    function automatic int model_len(input int nb, input int div, input logic [1:0] mode, input logic two);
        int nbits;
        nbits = 1 + nb + (((mode == 2'b01) || (mode == 2'b10)) ? 1 : 0) + (two ? 2 : 1);
        return nbits * (div + 1);
    endfunction

    // Expected line level at cycle i after the start bit begins.
    function automatic logic model_tx(input int i, input logic [8:0] d, input int nb,
                                      input int div, input logic [1:0] mode);
        int   k;
        logic p;
        k = i / (div + 1);
        if (k == 0) return 1'b0;
        if (k <= nb) return d[k-1];
        k = k - nb - 1;
        if ((mode == 2'b01) || (mode == 2'b10)) begin
            if (k == 0) begin
                p = 1'b0;
                for (int j = 0; j < nb; j++) p = p ^ d[j];
                return (mode == 2'b10) ? ~p : p;
            end
        end
        return 1'b1;
    endfunction

    task automatic push(input bit sel, input logic [8:0] d);
        if (sel) begin
            bus5.wr_en   = 1'b1;
            bus5.tx_data = d[4:0];
        end else begin
            bus8.wr_en   = 1'b1;
            bus8.tx_data = d[7:0];
        end
        @(negedge clk);
        bus5.wr_en = 1'b0;
        bus8.wr_en = 1'b0;
    endtask

    task automatic expect_frame(input bit sel, input logic [8:0] d, input int nb, input int div,
                                input logic [1:0] mode, input logic two, input int max_wait,
                                input string tag, output logic [15:0] cap, output int done_at);
        int   w;
        int   len;
        int   bad;
        logic t;
        logic bad_exp;
        w       = 0;
        bad     = -1;
        bad_exp = 1'b0;
        cap     = '0;
        done_at = -1;
        len     = model_len(nb, div, mode, two);
        while (txs(sel) !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (txs(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s start: TX=%b after %0d cycles, required 0", tag, txs(sel), max_wait);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            t = txs(sel);
            if (i % (div + 1) == 0) cap[i / (div + 1)] = t;
            if (bad < 0 && t !== model_tx(i, d, nb, div, mode)) begin
                bad     = i;
                bad_exp = model_tx(i, d, nb, div, mode);
            end
            if (done_at < 0 && dones(sel) === 1'b1) done_at = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s wave: TX=%b at cycle %0d of %0d, required %b", tag, ~bad_exp, bad, len, bad_exp);
        end
        chk({tag, " done_pos"}, done_at, len - 1);
    endtask

    task automatic wait_done(input bit sel, input int max_cycles, input string tag);
        for (int w = 0; w < max_cycles; w++) begin
            if (dones(sel) === 1'b1) begin
                checks++;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: tx_done=0 after %0d cycles, required 1", tag, max_cycles);
    endtask

    task automatic quiet(input bit sel, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (txs(sel) !== 1'b1 || busys(sel) !== 1'b0) bad++;
            @(negedge clk);
        end
        chk({tag, " idle_violations"}, bad, 0);
    endtask

    initial begin
        logic [15:0] cap;
        int          da;
        int          snap;
        int          mcount;
        bit          exp_drop;
        bit          s;
        int          nb;
        int          rdiv;
        logic [1:0]  rmode;
        logic        rtwo;
        logic [8:0]  d;
        logic [8:0]  q[$];

        vecs[0] = '{9'h0A5, 3, 2'b00, 1'b0, 16'h034A, 40};
        vecs[1] = '{9'h007, 1, 2'b01, 1'b0, 16'h060E, 22};
        vecs[2] = '{9'h007, 1, 2'b10, 1'b0, 16'h040E, 22};
        vecs[3] = '{9'h007, 1, 2'b11, 1'b0, 16'h020E, 20};
        vecs[4] = '{9'h007, 1, 2'b00, 1'b0, 16'h020E, 20};
        vecs[5] = '{9'h03C, 2, 2'b01, 1'b1, 16'h0C78, 36};
        vecs[6] = '{9'h0FF, 0, 2'b10, 1'b1, 16'h0FFE, 12};
        vecs[7] = '{9'h000, 0, 2'b00, 1'b0, 16'h0200, 10};

        bus8.wr_en = 1'b0; bus8.tx_data = '0;
        bus5.wr_en = 1'b0; bus5.tx_data = '0;
        div8 = 16'd0; pm8 = PAR_NONE; ts8 = 1'b0;
        div5 = 16'd0; pm5 = PAR_NONE; ts5 = 1'b0;
        rst = 1'b1;

        // Reset takes effect before the first clock edge.
        #1;
        chk("rst_tx", tx8, 1);
        chk("rst_empty", bus8.empty, 1);
        chk("rst_full", bus8.full, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_ovf", bus8.overflow, 0);
        chk("rst_tx5", tx5, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: the first write lands on the very first edge after reset release.
        foreach (vecs[i]) begin
            div8 = 16'(vecs[i].div);
            pm8  = vecs[i].mode;
            ts8  = vecs[i].two;
            push(1'b0, vecs[i].data);
            expect_frame(1'b0, vecs[i].data, 8, vecs[i].div, vecs[i].mode, vecs[i].two, 6,
                         $sformatf("vec%0d", i), cap, da);
            chk($sformatf("vec%0d bits", i), int'(cap), int'(vecs[i].exp_bits));
            chk($sformatf("vec%0d cycles", i), da + 1, vecs[i].exp_cycles);
        end
        @(negedge clk);

        // Write-to-start-bit latency.
        div8 = 16'd1; pm8 = PAR_NONE; ts8 = 1'b0;
        bus8.wr_en = 1'b1; bus8.tx_data = 8'h5A;
        @(negedge clk);
        bus8.wr_en = 1'b0;
        chk("lat_empty_N", bus8.empty, 0);
        chk("lat_tx_N", tx8, 1);
        @(negedge clk);
        chk("lat_tx_N1", tx8, 1);
        chk("lat_busy_N1", busy8, 1);
        @(negedge clk);
        chk("lat_tx_N2", tx8, 0);
        wait_done(1'b0, 40, "lat_done");
        @(negedge clk);

        // Back-to-back frames without an idle gap.
        snap = done_cnt8;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            d = 9'($urandom_range(0, 255));
            q.push_back(d);
            push(1'b0, d);
        end
        expect_frame(1'b0, q[0], 8, 1, PAR_NONE, 1'b0, 6, "b2b0", cap, da);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            expect_frame(1'b0, q[k], 8, 1, PAR_NONE, 1'b0, 0, $sformatf("b2b%0d", k), cap, da);
        end
        @(negedge clk);
        chk("b2b_done_count", done_cnt8 - snap, 3);

        // Overflow while the first frame is stalled on a long bit period.
        snap = done_cnt8;
        div8 = 16'd200;
        push(1'b0, 9'h0F0);
        repeat (3) @(negedge clk);
        div8 = 16'd0;
        mcount = 0;
        q.delete();
        for (int k = 0; k < 9; k++) begin
            d = 9'($urandom_range(0, 255));
            exp_drop = (mcount == 8);
            if (!exp_drop) begin
                q.push_back(d);
                mcount++;
            end
            push(1'b0, d);
            chk($sformatf("ovf_pulse%0d", k), bus8.overflow, int'(exp_drop));
            if (k == 7) chk("full_after8", bus8.full, 1);
        end
        @(negedge clk);
        chk("ovf_clear", bus8.overflow, 0);
        wait_done(1'b0, 2200, "ovf_first_done");
        foreach (q[k]) begin
            @(negedge clk);
            expect_frame(1'b0, q[k], 8, 0, PAR_NONE, 1'b0, 0, $sformatf("ovf_frame%0d", k), cap, da);
        end
        @(negedge clk);
        quiet(1'b0, 30, "ovf_tail");
        chk("ovf_done_count", done_cnt8 - snap, 9);

        // Reset in the middle of the data bits with words still queued.
        div8 = 16'd5;
        for (int k = 0; k < 5; k++) push(1'b0, 9'h000);
        repeat (12) @(negedge clk);
        chk("rstmid_pre_tx", tx8, 0);
        chk("rstmid_pre_busy", busy8, 1);
        snap = done_cnt8;
        #2 rst = 1'b1;
        #1;
        chk("rstmid_tx", tx8, 1);
        chk("rstmid_empty", bus8.empty, 1);
        chk("rstmid_busy", busy8, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet(1'b0, 40, "rstmid_quiet");
        chk("rstmid_done_count", done_cnt8 - snap, 0);
        div8 = 16'd1;
        push(1'b0, 9'h0C3);
        expect_frame(1'b0, 9'h0C3, 8, 1, PAR_NONE, 1'b0, 6, "rstmid_new", cap, da);
        @(negedge clk);

        // 5-bit frame with odd parity and two stops; config changes once the word is latched.
        div5 = 16'd0; pm5 = PAR_ODD; ts5 = 1'b1;
        d = 9'($urandom_range(0, 31));
        push(1'b1, d);
        @(negedge clk);
        div5 = 16'd7; pm5 = PAR_NONE; ts5 = 1'b0;
        expect_frame(1'b1, d, 5, 0, PAR_ODD, 1'b1, 6, "w5_corner", cap, da);
        chk("w5_corner cycles", da + 1, 9);
        @(negedge clk);

        // Randomized frames on both widths against the model.
        for (int r = 0; r < 8; r++) begin
            s     = 1'($urandom_range(0, 1));
            nb    = s ? 5 : 8;
            d     = 9'($urandom) & (s ? 9'h01F : 9'h0FF);
            rdiv  = int'($urandom_range(0, 3));
            rmode = 2'($urandom_range(0, 3));
            rtwo  = 1'($urandom_range(0, 1));
            if (s) begin
                div5 = 16'(rdiv); pm5 = rmode; ts5 = rtwo;
            end else begin
                div8 = 16'(rdiv); pm8 = rmode; ts8 = rtwo;
            end
            push(s, d);
            expect_frame(s, d, nb, rdiv, rmode, rtwo, 6, $sformatf("rnd%0d", r), cap, da);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 8: TX FIFO entries, a power of 2, minimum 2.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port wr_en, input, 1: push tx_data into the FIFO this cycle.
REQ-006 Port tx_data, input, DATA_W: word to enqueue.
REQ-007 Port baud_div, input, 16: each bit lasts baud_div+1 clk cycles.
REQ-008 Port parity_mode, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port two_stop, input, 1: 0 gives one stop bit, 1 gives two.
REQ-010 Port TX, output, 1: serial line, idle high.
REQ-011 Port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-012 Port empty, output, 1: FIFO holds 0 entries.
REQ-013 Port tx_busy, output, 1: a frame is in progress (state not IDLE).
REQ-014 Port tx_done, output, 1: one-cycle pulse at the end of each frame.
REQ-015 Port overflow, output, 1: one-cycle pulse when a write is dropped.

Function
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 In IDLE with !empty, the FSM SHALL pop the FIFO head and latch the word, baud_div, parity_mode and two_stop; the next state is START.
REQ-018 A change to any configuration input mid-frame SHALL NOT affect the current frame.
REQ-019 TX SHALL be registered with the following values:
 - START: 0
 - DATA: data bits, LSB first
 - PARITY: parity bit
 - STOP: 1
 - IDLE: 1
REQ-020 Each bit SHALL be held exactly latched_baud_div+1 cycles; baud_div=0 gives one cycle per bit.
REQ-021 DATA SHALL last DATA_W bit periods, tracked by a bit counter sized for 9.
REQ-022 PARITY SHALL be entered only when mode is 01 or 10; otherwise DATA goes directly to STOP.
REQ-023 The parity bit SHALL be the XOR of the data bits for even mode and its inverse for odd mode.
REQ-024 STOP SHALL last 1 or 2 bit periods according to latched two_stop.
REQ-025 At the end of STOP, tx_done SHALL pulse for 1 cycle.
REQ-026 At the end of STOP with !empty, the FSM SHALL pop and enter START directly, with no idle gap between frames.
REQ-027 At the end of STOP with empty, the FSM SHALL return to IDLE.
REQ-028 Latency: wr_en sampled at edge N into an idle, empty block SHALL drive TX low after edge N+2.
REQ-029 A write when full SHALL be dropped, with FIFO contents unchanged and overflow pulsing 1 cycle.
REQ-030 A simultaneous write and pop when full SHALL be accepted, because the pop frees a slot in the same cycle.
REQ-031 A simultaneous write and pop when empty SHALL NOT occur, because a pop requires !empty.
REQ-032 FIFO read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-033 full and empty SHALL be decoded combinationally from the pointers.

Reset
REQ-034 On rst assertion, the block SHALL immediately, without waiting for clk, set all of the following:
 - TX=1
 - state IDLE
 - FIFO pointers and all counters 0
 - empty=1, full=0
 - tx_busy=0, tx_done=0, overflow=0
REQ-035 Reset mid-frame SHALL abort the frame and discard all queued data; no tx_done pulse is generated.
REQ-036 After rst deasserts, the block SHALL accept a write on the first clk edge.

Structure
REQ-037 Package uart_pkg SHALL hold the FSM state enum type and the parity_mode encodings.
REQ-038 The FIFO SHALL be a sub-module, uart_fifo, parametrised by width and depth, providing wr_en, rd_en, din, dout, full and empty.
REQ-039 Parameter legality (DATA_W range, power-of-2 FIFO_DEPTH) SHALL be checked at elaboration.

Verification
REQ-040 Single frame: write 8'hA5, baud_div=3, parity none, one stop bit. TX shall carry 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses after 40 cycles.
REQ-041 Parity: data 8'h07 shall give parity bit 1 in even mode and 0 in odd mode. Mode 11 shall produce the same frame as none.
REQ-042 Back-to-back: write 3 words in consecutive cycles. The next start bit shall follow each stop bit with no gap, producing 3 tx_done pulses.
REQ-043 Overflow: with FIFO_DEPTH=8, 9 writes while TX is stalled (large baud_div) shall set full after 8 accepted writes. The 9th shall pulse overflow and be dropped, and exactly 8 frames follow.
REQ-044 Reset mid-frame: assert rst during DATA with 4 words queued. TX shall go high immediately and empty=1. No frame or tx_done follows until a new write.
REQ-045 Corner: baud_div=0 with DATA_W=5, two_stop=1 and odd parity shall give a 9-cycle frame. baud_div changed mid-frame shall not alter that frame.
